// File: rtl/icache_fetcher_pkg.sv
// Shared scheduler, fetcher and LSU state enums for the core pipeline.
package icache_fetcher_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } corestate_t;

    typedef enum logic [2:0] {
        FETCH_IDLE     = 3'b000,
        FETCH_FETCHING = 3'b001,
        FETCH_FETCHED  = 3'b010
    } fetchstate_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsustate_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: async lookup, sync write and flush.
module icache_array #(
    parameter int unsigned LINES     = 8,
    parameter int unsigned TAG_BITS  = 5,
    parameter int unsigned DATA_BITS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [$clog2(LINES)-1:0]   lookup_index,
    output logic                       lookup_valid,
    output logic [TAG_BITS-1:0]        lookup_tag,
    output logic [DATA_BITS-1:0]       lookup_data,
    input  logic                       write_en,
    input  logic [$clog2(LINES)-1:0]   write_index,
    input  logic [TAG_BITS-1:0]        write_tag,
    input  logic [DATA_BITS-1:0]       write_data
);

    logic [LINES-1:0]     valid_bits;
    logic [TAG_BITS-1:0]  tags  [LINES];
    logic [DATA_BITS-1:0] lines [LINES];

    // Flush wins over a same-cycle fill so the freshly written line stays invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
        end else if (flush) begin
            valid_bits <= '0;
        end else if (write_en) begin
            valid_bits[write_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            tags[write_index]  <= write_tag;
            lines[write_index] <= write_data;
        end
    end

    assign lookup_valid = valid_bits[lookup_index];
    assign lookup_tag   = tags[lookup_index];
    assign lookup_data  = lines[lookup_index];

endmodule

// File: rtl/icache_fetcher.sv
// Instruction fetch stage: cache lookup, program-memory handshake on miss, hit/miss statistics.
module icache_fetcher
    import icache_fetcher_pkg::*;
#(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned CACHE_LINES           = 8,
    parameter int unsigned COUNT_BITS            = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  corestate_t                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output fetchstate_t                      fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNT_BITS-1:0]            hit_count,
    output logic [COUNT_BITS-1:0]            miss_count
);

    localparam int unsigned IDX      = $clog2(CACHE_LINES);
    localparam int unsigned TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX;

    logic                             line_valid;
    logic [TAG_BITS-1:0]              line_tag;
    logic [PROGRAM_MEM_DATA_BITS-1:0] line_data;
    logic                             hit;
    logic                             fill_en;

    assign hit     = line_valid && (line_tag == current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX]);
    assign fill_en = (fetcher_state == FETCH_FETCHING) && mem_read_ready;

    // The fill uses the latched request address, not the live PC.
    icache_array #(
        .LINES     (CACHE_LINES),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .lookup_index (current_pc[IDX-1:0]),
        .lookup_valid (line_valid),
        .lookup_tag   (line_tag),
        .lookup_data  (line_data),
        .write_en     (fill_en),
        .write_index  (mem_read_address[IDX-1:0]),
        .write_tag    (mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX]),
        .write_data   (mem_read_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetcher_state    <= FETCH_IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            case (fetcher_state)
                FETCH_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (hit) begin
                            instruction   <= line_data;
                            fetcher_state <= FETCH_FETCHED;
                            if (hit_count != '1) hit_count <= hit_count + COUNT_BITS'(1);
                        end else begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= current_pc;
                            fetcher_state    <= FETCH_FETCHING;
                            if (miss_count != '1) miss_count <= miss_count + COUNT_BITS'(1);
                        end
                    end
                end
                FETCH_FETCHING: begin
                    if (mem_read_ready) begin
                        instruction    <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        fetcher_state  <= FETCH_FETCHED;
                    end
                end
                FETCH_FETCHED: begin
                    if (core_state == CORE_DECODE) fetcher_state <= FETCH_IDLE;
                end
                default: begin
                    fetcher_state  <= FETCH_IDLE;
                    mem_read_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetcher.sv
// Randomized self-checking bench for icache_fetcher against a line-level cache model.
module tb_icache_fetcher;
    import icache_fetcher_pkg::*;

    localparam int LINES = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    corestate_t  core_state = CORE_IDLE;
    logic [7:0]  current_pc = '0;
    logic        flush = 1'b0;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready = 1'b0;
    logic [15:0] mem_read_data = '0;
    fetchstate_t fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    corestate_t  s_core = CORE_IDLE;
    logic [7:0]  s_pc = '0;
    logic        s_ready = 1'b0;
    logic        s_valid;
    logic [7:0]  s_addr;
    fetchstate_t s_state;
    logic [15:0] s_instr;
    logic [3:0]  s_hits;
    logic [3:0]  s_misses;

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per line plus a program image.
    bit          mdl_valid [LINES];
    logic [4:0]  mdl_tag   [LINES];
    logic [15:0] mdl_line  [LINES];
    logic [15:0] mem_image [256];
    int          mdl_hits;
    int          mdl_misses;

    always #5 clk = ~clk;

    icache_fetcher dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .flush            (flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    icache_fetcher #(.COUNT_BITS(4)) dut_sat (
        .clk              (clk),
        .reset            (reset),
        .core_state       (s_core),
        .current_pc       (s_pc),
        .flush            (1'b0),
        .mem_read_valid   (s_valid),
        .mem_read_address (s_addr),
        .mem_read_ready   (s_ready),
        .mem_read_data    (16'h00AA),
        .fetcher_state    (s_state),
        .instruction      (s_instr),
        .hit_count        (s_hits),
        .miss_count       (s_misses)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_lines();
        for (int i = 0; i < LINES; i++) mdl_valid[i] = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_clear_lines();
        mdl_hits   = 0;
        mdl_misses = 0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear_lines();
    endtask

    task automatic do_fetch(input logic [7:0] pc, input int delay, input bit flush_at_ready,
                            input bit flush_mid);
        int         idx;
        logic [4:0] tag;
        bit         exp_hit;
        logic [15:0] exp_instr;
        idx     = int'(pc % LINES);
        tag     = 5'(pc / LINES);
        exp_hit = mdl_valid[idx] && (mdl_tag[idx] == tag);
        current_pc = pc;
        core_state = CORE_FETCH;
        step();
        current_pc = 8'($urandom);
        if (exp_hit) begin
            mdl_hits++;
            exp_instr = mdl_line[idx];
            checks++;
            if (fetcher_state !== FETCH_FETCHED || mem_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL hit_state pc=%0h: state=%0d valid=%0b want state=2 valid=0",
                         pc, fetcher_state, mem_read_valid);
            end
        end else begin
            mdl_misses++;
            exp_instr = mem_image[pc];
            checks++;
            if (fetcher_state !== FETCH_FETCHING || mem_read_valid !== 1'b1 ||
                mem_read_address !== pc) begin
                errors++;
                $display("FAIL miss_req pc=%0h: state=%0d valid=%0b addr=%0h want 1/1/%0h",
                         pc, fetcher_state, mem_read_valid, mem_read_address, pc);
            end
            for (int i = 1; i < delay; i++) begin
                if (flush_mid && i == 1) flush = 1'b1;
                current_pc = 8'($urandom);
                step();
                if (flush) begin
                    flush = 1'b0;
                    model_clear_lines();
                end
                checks++;
                if (mem_read_valid !== 1'b1 || mem_read_address !== pc) begin
                    errors++;
                    $display("FAIL req_hold pc=%0h: valid=%0b addr=%0h want 1/%0h",
                             pc, mem_read_valid, mem_read_address, pc);
                end
            end
            mem_read_ready = 1'b1;
            mem_read_data  = mem_image[pc];
            flush          = flush_at_ready;
            step();
            mem_read_ready = 1'b0;
            mem_read_data  = 16'($urandom);
            flush          = 1'b0;
            if (flush_at_ready) begin
                model_clear_lines();
            end else begin
                mdl_valid[idx] = 1'b1;
                mdl_tag[idx]   = tag;
                mdl_line[idx]  = mem_image[pc];
            end
            checks++;
            if (fetcher_state !== FETCH_FETCHED || mem_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill_done pc=%0h: state=%0d valid=%0b want 2/0",
                         pc, fetcher_state, mem_read_valid);
            end
        end
        checks++;
        if (instruction !== exp_instr) begin
            errors++;
            $display("FAIL instr pc=%0h: got %0h want %0h", pc, instruction, exp_instr);
        end
        // Stay in FETCH with a stray ready: no second lookup, instruction held.
        mem_read_ready = 1'b1;
        mem_read_data  = ~exp_instr;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (fetcher_state !== FETCH_FETCHED || instruction !== exp_instr) begin
            errors++;
            $display("FAIL fetched_hold pc=%0h: state=%0d instr=%0h want 2/%0h",
                     pc, fetcher_state, instruction, exp_instr);
        end
        checks++;
        if (hit_count !== 16'(mdl_hits) || miss_count !== 16'(mdl_misses)) begin
            errors++;
            $display("FAIL counters pc=%0h: hits=%0d misses=%0d want %0d/%0d",
                     pc, hit_count, miss_count, mdl_hits, mdl_misses);
        end
        core_state = CORE_DECODE;
        step();
        core_state = CORE_IDLE;
        checks++;
        if (fetcher_state !== FETCH_IDLE) begin
            errors++;
            $display("FAIL decode_idle pc=%0h: state=%0d want 0", pc, fetcher_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (fetcher_state !== FETCH_IDLE || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 ||
            instruction !== 16'h0 || hit_count !== 16'h0 || miss_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_vals: st=%0d v=%0b a=%0h i=%0h h=%0d m=%0d want all 0",
                     fetcher_state, mem_read_valid, mem_read_address, instruction,
                     hit_count, miss_count);
        end
        apply_reset();
    endtask

    task automatic test_cold_miss();
        mem_image[8'h05] = 16'h9123;
        do_fetch(8'h05, 3, 1'b0, 1'b0);
        checks++;
        if (miss_count !== 16'd1 || instruction !== 16'h9123) begin
            errors++;
            $display("FAIL cold_miss: misses=%0d instr=%0h want 1/9123", miss_count, instruction);
        end
    endtask

    task automatic test_hit();
        do_fetch(8'h05, 1, 1'b0, 1'b0);
        checks++;
        if (hit_count !== 16'd1 || instruction !== 16'h9123) begin
            errors++;
            $display("FAIL hit: hits=%0d instr=%0h want 1/9123", hit_count, instruction);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        do_fetch(8'h05, 2, 1'b0, 1'b0);
        do_fetch(8'h0D, 2, 1'b0, 1'b0);
        do_fetch(8'h05, 2, 1'b0, 1'b0);
        checks++;
        if (miss_count !== 16'd3 || hit_count !== 16'd0) begin
            errors++;
            $display("FAIL conflict: misses=%0d hits=%0d want 3/0", miss_count, hit_count);
        end
        do_fetch(8'h05, 1, 1'b0, 1'b0);
        checks++;
        if (hit_count !== 16'd1) begin
            errors++;
            $display("FAIL conflict_tag0_hit: hits=%0d want 1", hit_count);
        end
    endtask

    task automatic test_flush();
        int misses_before;
        do_flush();
        misses_before = mdl_misses;
        do_fetch(8'h05, 1, 1'b0, 1'b0);
        do_fetch(8'h22, 2, 1'b1, 1'b0);
        do_fetch(8'h22, 1, 1'b0, 1'b0);
        checks++;
        if (miss_count !== 16'(misses_before + 3)) begin
            errors++;
            $display("FAIL flush_misses: got %0d want %0d", miss_count, misses_before + 3);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 15) == 0) do_flush();
            do_fetch(8'($urandom_range(0, 23)), int'($urandom_range(1, 4)),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        current_pc = 8'h41;
        core_state = CORE_FETCH;
        step();
        current_pc = 8'h00;
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_read_valid !== 1'b0 || fetcher_state !== FETCH_IDLE || hit_count !== 16'h0 ||
            miss_count !== 16'h0 || instruction !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: v=%0b st=%0d h=%0d m=%0d i=%0h want all 0",
                     mem_read_valid, fetcher_state, hit_count, miss_count, instruction);
        end
        core_state = CORE_IDLE;
        step();
        reset = 1'b0;
        model_clear_lines();
        mdl_hits   = 0;
        mdl_misses = 0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (fetcher_state !== FETCH_IDLE || mem_read_valid !== 1'b0 || instruction !== 16'h0) begin
            errors++;
            $display("FAIL stray_ready: st=%0d v=%0b i=%0h want 0/0/0",
                     fetcher_state, mem_read_valid, instruction);
        end
        do_fetch(8'h41, 2, 1'b0, 1'b0);
    endtask

    task automatic s_fetch(input logic [7:0] pc);
        s_pc   = pc;
        s_core = CORE_FETCH;
        step();
        if (s_state == FETCH_FETCHING) begin
            s_ready = 1'b1;
            step();
            s_ready = 1'b0;
        end
        s_core = CORE_DECODE;
        step();
        s_core = CORE_IDLE;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 10; i++) s_fetch((i % 2 == 0) ? 8'h05 : 8'h0D);
        checks++;
        if (s_misses !== 4'd10 || s_hits !== 4'd0) begin
            errors++;
            $display("FAIL sat_misses10: got %0d/%0d want 10/0", s_misses, s_hits);
        end
        for (int i = 10; i < 20; i++) s_fetch((i % 2 == 0) ? 8'h05 : 8'h0D);
        checks++;
        if (s_misses !== 4'hF) begin
            errors++;
            $display("FAIL sat_misses_cap: got %0d want 15", s_misses);
        end
        for (int i = 0; i < 10; i++) s_fetch(8'h0D);
        checks++;
        if (s_hits !== 4'd10) begin
            errors++;
            $display("FAIL sat_hits10: got %0d want 10", s_hits);
        end
        for (int i = 0; i < 10; i++) s_fetch(8'h0D);
        checks++;
        if (s_hits !== 4'hF || s_misses !== 4'hF) begin
            errors++;
            $display("FAIL sat_hits_cap: got %0d/%0d want 15/15", s_hits, s_misses);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_image[i] = 16'($urandom);
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_random();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
